clk_rst_trace_engine: RTL and testbench

Synthesisable, parametrised successor to the trace agent's clock/reset interface.
- Dump mode: samples NUM_CH reset/enable-style lines every cycle, timestamps each change against a free-running cycle counter, and streams snapshot records out through an internal FIFO.
- Replay mode: consumes the same record format and re-drives the lines at the recorded cycle counts.
- Sits between the DUT-side control signals and the hwemu trace dump/reader path.

---
 rtl/clk_rst_trace_pkg.sv | 19 +
 rtl/trace_sync_fifo.sv | 45 ++++
 rtl/clk_rst_trace_engine.sv | 149 ++++++++++++++
 tb/tb_clk_rst_trace_engine.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_rst_trace_pkg.sv
// Shared types and constants for the clock/reset trace engine.
// Record layout is {type, cnt, values} with the type bit in the MSB.
package clk_rst_trace_pkg;

   typedef enum logic [2:0] {IDLE, INIT, RUN, LOAD, PLAY} state_t;

   localparam logic MODE_DUMP   = 1'b0;
   localparam logic MODE_REPLAY = 1'b1;

   localparam logic REC_INIT    = 1'b0;
   localparam logic REC_CHANGE  = 1'b1;

   localparam int OVF_W = 16;

   function automatic logic [OVF_W-1:0] sat_inc(input logic [OVF_W-1:0] v);
      return (&v) ? v : v + OVF_W'(1);
   endfunction

endpackage

// File: rtl/trace_sync_fifo.sv
// Single-clock record FIFO; pointers carry an extra wrap bit to tell full from empty.
// A push while full is accepted when a pop happens on the same edge.
module trace_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   // Head reads as zero while empty so the output is clean out of reset.
   assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/clk_rst_trace_engine.sv
// Clock/reset trace engine: dumps timestamped snapshots of monitored lines,
// or replays recorded snapshots onto drv_out at their recorded cycle counts.
module clk_rst_trace_engine
   import clk_rst_trace_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 48,
   parameter int DEPTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  mode,
   input  logic [NUM_CH-1:0]     mon_in,
   output logic                  rec_out_valid,
   input  logic                  rec_out_ready,
   output logic [CNT_W+NUM_CH:0] rec_out_data,
   input  logic                  rec_in_valid,
   output logic                  rec_in_ready,
   input  logic [CNT_W+NUM_CH:0] rec_in_data,
   output logic [NUM_CH-1:0]     drv_out,
   output logic [CNT_W-1:0]      clkcnt,
   output logic [OVF_W-1:0]      ovf_cnt,
   output logic                  late,
   output logic                  busy
);
   localparam int REC_W = 1 + CNT_W + NUM_CH;

   state_t            state;
   state_t            state_nxt;
   logic              enable_q;
   logic [NUM_CH-1:0] mon_q;
   logic [CNT_W-1:0]  hold_cnt;
   logic [NUM_CH-1:0] hold_vals;
   logic              hold_valid;
   logic              push;
   logic              pop;
   logic              full;
   logic              empty;
   logic              start;
   logic              load_init;
   logic              apply;
   logic [REC_W-1:0]  push_data;
   logic              in_type;
   logic [CNT_W-1:0]  in_cnt;
   logic [NUM_CH-1:0] in_vals;

   assign in_type       = rec_in_data[REC_W-1];
   assign in_cnt        = rec_in_data[REC_W-2:NUM_CH];
   assign in_vals       = rec_in_data[NUM_CH-1:0];
   assign busy          = (state != IDLE);
   assign rec_out_valid = !empty;
   assign pop           = !empty && rec_out_ready;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Dropping enable wins over everything; no record is pushed or applied that cycle.
   always_comb begin
      state_nxt    = state;
      push         = 1'b0;
      push_data    = {REC_CHANGE, clkcnt, mon_in};
      rec_in_ready = 1'b0;
      start        = 1'b0;
      load_init    = 1'b0;
      apply        = 1'b0;
      if (!enable) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: if (!enable_q) begin
               start     = 1'b1;
               state_nxt = (mode == MODE_DUMP) ? INIT : LOAD;
            end
            INIT: begin
               push      = 1'b1;
               push_data = {REC_INIT, {CNT_W{1'b0}}, mon_in};
               state_nxt = RUN;
            end
            RUN:  push = (mon_in != mon_q);
            LOAD: begin
               rec_in_ready = 1'b1;
               if (rec_in_valid && in_type == REC_INIT) begin
                  load_init = 1'b1;
                  state_nxt = PLAY;
               end
            end
            PLAY: begin
               apply        = hold_valid && (clkcnt >= hold_cnt);
               rec_in_ready = !hold_valid || apply;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         enable_q   <= 1'b0;
         clkcnt     <= '0;
         mon_q      <= '0;
         hold_cnt   <= '0;
         hold_vals  <= '0;
         hold_valid <= 1'b0;
         drv_out    <= '0;
         ovf_cnt    <= '0;
         late       <= 1'b0;
      end else begin
         enable_q <= enable;
         if (start || load_init)  clkcnt <= '0;
         else if (state != IDLE)  clkcnt <= clkcnt + CNT_W'(1);
         // mon_q tracks the lines even when the record itself is dropped.
         if (enable && (state == INIT || state == RUN)) mon_q <= mon_in;
         if (push && full && !pop) ovf_cnt <= sat_inc(ovf_cnt);
         if (load_init) begin
            drv_out <= in_vals;
         end else if (apply) begin
            drv_out <= hold_vals;
            if (clkcnt > hold_cnt) late <= 1'b1;
         end
         if (!enable) begin
            hold_valid <= 1'b0;
         end else if (state == PLAY && rec_in_valid && rec_in_ready) begin
            hold_cnt   <= in_cnt;
            hold_vals  <= in_vals;
            hold_valid <= 1'b1;
         end else if (apply) begin
            hold_valid <= 1'b0;
         end
      end
   end

   trace_sync_fifo #(
      .WIDTH (REC_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .pop_data  (rec_out_data),
      .full      (full),
      .empty     (empty)
   );

endmodule

// File: tb/tb_clk_rst_trace_engine.sv
// Bench for clk_rst_trace_engine: dump vector table, overflow/replay/stop/reset/wrap
// sequences, and a randomized dump session checked against a queue model.
module tb_clk_rst_trace_engine;

   logic        clk = 1'b0;
   logic        rst, enable, mode, rec_out_ready, rec_in_valid;
   logic [3:0]  mon_in;
   logic [52:0] rec_in_data;
   logic        rec_out_valid, rec_in_ready, late, busy;
   logic [52:0] rec_out_data;
   logic [3:0]  drv_out;
   logic [47:0] clkcnt;
   logic [15:0] ovf_cnt;

   logic        enable1, ready1;
   logic [3:0]  mon1;
   logic        rec_out_valid1, rec_in_ready1, late1, busy1;
   logic [8:0]  rec_out_data1;
   logic [3:0]  drv_out1, clkcnt1;
   logic [15:0] ovf_cnt1;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   clk_rst_trace_engine #(.NUM_CH(4), .CNT_W(48), .DEPTH(4)) u_dut (
      .clk(clk), .rst(rst), .enable(enable), .mode(mode), .mon_in(mon_in),
      .rec_out_valid(rec_out_valid), .rec_out_ready(rec_out_ready), .rec_out_data(rec_out_data),
      .rec_in_valid(rec_in_valid), .rec_in_ready(rec_in_ready), .rec_in_data(rec_in_data),
      .drv_out(drv_out), .clkcnt(clkcnt), .ovf_cnt(ovf_cnt), .late(late), .busy(busy));

   clk_rst_trace_engine #(.NUM_CH(4), .CNT_W(4), .DEPTH(4)) u_wrap (
      .clk(clk), .rst(rst), .enable(enable1), .mode(1'b0), .mon_in(mon1),
      .rec_out_valid(rec_out_valid1), .rec_out_ready(ready1), .rec_out_data(rec_out_data1),
      .rec_in_valid(1'b0), .rec_in_ready(rec_in_ready1), .rec_in_data(9'd0),
      .drv_out(drv_out1), .clkcnt(clkcnt1), .ovf_cnt(ovf_cnt1), .late(late1), .busy(busy1));

   typedef struct {
      logic [3:0]  init;
      int          at;
      logic [3:0]  nv;
      logic [52:0] e0;
      logic [52:0] e1;
   } row_t;

   row_t rows[4];
   logic [52:0] exp_q[$];

   function automatic logic [52:0] rec(input logic t, input logic [47:0] c, input logic [3:0] v);
      return {t, c, v};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; enable = 1'b0; mode = 1'b0; mon_in = 4'd0; rec_out_ready = 1'b0;
      rec_in_valid = 1'b0; rec_in_data = '0; enable1 = 1'b0; mon1 = 4'd0; ready1 = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [47:0] c;
      logic        r;
      logic [3:0]  prev;
      logic [47:0] mcnt;
      logic [15:0] movf;
      logic        mpush;
      logic [52:0] nrec;
      int          g;
      bit          seen20, seen21;

      rows[0] = '{4'b0001, 10, 4'b0011, rec(0, 0, 4'b0001), rec(1, 10, 4'b0011)};
      rows[1] = '{4'b0001,  5, 4'b1000, rec(0, 0, 4'b0001), rec(1,  5, 4'b1000)};
      rows[2] = '{4'b1111,  2, 4'b0000, rec(0, 0, 4'b1111), rec(1,  2, 4'b0000)};
      rows[3] = '{4'b0110,  7, 4'b0111, rec(0, 0, 4'b0110), rec(1,  7, 4'b0111)};

      // Reset state
      do_reset();
      chk("rst_valid", rec_out_valid, 0);
      chk("rst_data", rec_out_data, 0);
      chk("rst_drv", drv_out, 0);
      chk("rst_clkcnt", clkcnt, 0);
      chk("rst_ovf", ovf_cnt, 0);
      chk("rst_late", late, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", rec_in_ready, 0);

      // Dump vector table: INIT record, then one change record one cycle after the change
      for (int i = 0; i < 4; i++) begin
         do_reset();
         mon_in = rows[i].init;
         enable = 1'b1;
         tick();
         chk("tbl_busy", busy, 1);
         tick();
         chk("tbl_init_rec", rec_out_data, rows[i].e0);
         rec_out_ready = 1'b1;
         tick();
         rec_out_ready = 1'b0;
         chk("tbl_drained", rec_out_valid, 0);
         g = 0;
         while (clkcnt != 48'(rows[i].at) && g < 100) begin
            tick();
            g++;
         end
         chk("tbl_reach_cnt", clkcnt, 48'(rows[i].at));
         mon_in = rows[i].nv;
         chk("tbl_valid_before", rec_out_valid, 0);
         tick();
         chk("tbl_valid_after", rec_out_valid, 1);
         chk("tbl_change_rec", rec_out_data, rows[i].e1);
         tick();
         chk("tbl_single_rec", ovf_cnt, 0);
      end

      // Overflow: DEPTH=4, six changes with no consumer
      do_reset();
      enable = 1'b1;
      tick();
      tick();
      exp_q = '{rec(0, 0, 4'd0), rec(1, 1, 4'd1), rec(1, 2, 4'd2), rec(1, 3, 4'd3)};
      for (int i = 1; i <= 6; i++) begin
         mon_in = 4'(i);
         tick();
      end
      chk("ovf_cnt", ovf_cnt, 3);
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("ovf_stall_data", rec_out_data, exp_q[0]);
      end
      rec_out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("ovf_drain_valid", rec_out_valid, 1);
         chk("ovf_drain_data", rec_out_data, exp_q[i]);
         tick();
      end
      rec_out_ready = 1'b0;
      chk("ovf_empty", rec_out_valid, 0);

      // Reset mid-RUN
      mon_in = 4'hA;
      tick();
      chk("midrun_valid", rec_out_valid, 1);
      rst = 1'b1;
      tick();
      chk("midrst_valid", rec_out_valid, 0);
      chk("midrst_data", rec_out_data, 0);
      chk("midrst_ovf", ovf_cnt, 0);
      chk("midrst_clkcnt", clkcnt, 0);
      chk("midrst_busy", busy, 0);
      rst = 1'b0;

      // Replay
      do_reset();
      mode = 1'b1;
      enable = 1'b1;
      tick();
      chk("rp_load_ready", rec_in_ready, 1);
      rec_in_valid = 1'b1;
      rec_in_data = rec(1, 5, 4'b1111);
      tick();
      chk("rp_discard_drv", drv_out, 0);
      chk("rp_still_load", rec_in_ready, 1);
      rec_in_data = rec(0, 0, 4'b0001);
      tick();
      chk("rp_init_drv", drv_out, 4'b0001);
      chk("rp_init_cnt", clkcnt, 0);
      rec_in_data = rec(1, 20, 4'b0000);
      tick();
      rec_in_data = rec(1, 20, 4'b0001);
      chk("rp_hold_full", rec_in_ready, 0);
      seen20 = 0;
      seen21 = 0;
      for (int k = 0; k < 60 && !seen21; k++) begin
         c = clkcnt;
         r = rec_in_ready;
         tick();
         if (r) rec_in_valid = 1'b0;
         if (c == 48'd19) chk("rp_pre_drv", drv_out, 4'b0001);
         if (c == 48'd20) begin
            seen20 = 1;
            chk("rp_accept20", r, 1);
            chk("rp_drv20", drv_out, 4'b0000);
            chk("rp_late20", late, 0);
         end
         if (c == 48'd21) begin
            seen21 = 1;
            chk("rp_drv21", drv_out, 4'b0001);
            chk("rp_late21", late, 1);
         end
      end
      chk("rp_reached", {seen20, seen21}, 2'b11);

      // Stop in PLAY
      enable = 1'b0;
      tick();
      chk("stop_busy", busy, 0);
      chk("stop_drv", drv_out, 4'b0001);
      tick();
      chk("stop_cnt_hold", clkcnt, 23);

      // Counter wrap on the CNT_W=4 instance
      do_reset();
      mon1 = 4'b0101;
      enable1 = 1'b1;
      tick();
      repeat (17) tick();
      mon1 = 4'b0111;
      tick();
      repeat (2) tick();
      chk("wrap_init_rec", rec_out_data1, {1'b0, 4'd0, 4'b0101});
      ready1 = 1'b1;
      tick();
      ready1 = 1'b0;
      chk("wrap_change_rec", rec_out_data1, {1'b1, 4'd1, 4'b0111});

      // Randomized dump against a queue model
      do_reset();
      mon_in = 4'($urandom);
      enable = 1'b1;
      tick();
      exp_q.delete();
      mcnt = '0;
      movf = '0;
      prev = '0;
      for (int k = 0; k < 400; k++) begin
         if (k > 0 && $urandom_range(0, 2) == 0) mon_in = 4'($urandom);
         rec_out_ready = 1'($urandom_range(0, 1));
         chk("rnd_valid", rec_out_valid, exp_q.size() != 0);
         if (exp_q.size() != 0) chk("rnd_data", rec_out_data, exp_q[0]);
         if (k % 50 == 0) chk("rnd_clkcnt", clkcnt, mcnt);
         if (exp_q.size() != 0 && rec_out_ready) void'(exp_q.pop_front());
         if (k == 0) begin
            mpush = 1'b1;
            nrec = rec(0, 0, mon_in);
         end else begin
            mpush = (mon_in != prev);
            nrec = rec(1, mcnt, mon_in);
         end
         if (mpush) begin
            if (exp_q.size() < 4) exp_q.push_back(nrec);
            else if (movf != 16'hFFFF) movf++;
         end
         prev = mon_in;
         mcnt++;
         tick();
      end
      chk("rnd_ovf", ovf_cnt, movf);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
